// File: rtl/qhv_fifo.sv
// Query hypervector holding block: a freely writable staging register feeding a
// committed-query FIFO that drains to the associative memory over valid/ready.
module qhv_fifo #(
    parameter  int HVDimension  = 512,
    parameter  int QHVFifoDepth = 4,
    localparam int PtrWidth     = (QHVFifoDepth > 1) ? $clog2(QHVFifoDepth) : 1,
    localparam int CntWidth     = $clog2(QHVFifoDepth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [HVDimension-1:0] qhv_i,
    input  logic                   qhv_wen_i,
    input  logic                   qhv_clr_i,
    input  logic                   qhv_am_load_i,
    output logic [HVDimension-1:0] qhv_o,
    output logic [HVDimension-1:0] am_qhv_o,
    output logic                   am_qhv_valid_o,
    input  logic                   am_qhv_ready_i,
    output logic                   qhv_stall_o,
    output logic [CntWidth-1:0]    qhv_count_o,
    output logic                   qhv_full_o,
    output logic                   qhv_empty_o
);

    logic [HVDimension-1:0] r_stage;
    logic [HVDimension-1:0] r_mem [QHVFifoDepth];
    logic [PtrWidth-1:0]    r_rd_ptr;
    logic [PtrWidth-1:0]    r_wr_ptr;
    logic [CntWidth-1:0]    r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic [PtrWidth-1:0]    w_rd_ptr_inc;
    logic [PtrWidth-1:0]    w_wr_ptr_inc;

    assign w_full  = (r_count == CntWidth'(QHVFifoDepth));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & am_qhv_ready_i;
    // A full FIFO still takes a commit when the head leaves in the same cycle.
    assign w_push  = qhv_am_load_i & (~w_full | w_pop);

    assign w_rd_ptr_inc = (r_rd_ptr == PtrWidth'(QHVFifoDepth - 1)) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_ptr_inc = (r_wr_ptr == PtrWidth'(QHVFifoDepth - 1)) ? '0 : r_wr_ptr + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stage  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (qhv_clr_i) begin
            r_stage  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (qhv_wen_i) r_stage  <= qhv_i;
            if (w_pop)     r_rd_ptr <= w_rd_ptr_inc;
            if (w_push)    r_wr_ptr <= w_wr_ptr_inc;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Each entry captures the staging value from before the edge, so a same-cycle
    // staging write never leaks into the committed query.
    generate
        for (genvar gi = 0; gi < QHVFifoDepth; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_mem[gi] <= '0;
                end else if (!qhv_clr_i && w_push && (r_wr_ptr == PtrWidth'(gi))) begin
                    r_mem[gi] <= r_stage;
                end
            end
        end
    endgenerate

    assign qhv_o          = r_stage;
    assign am_qhv_o       = r_mem[r_rd_ptr];
    assign am_qhv_valid_o = ~w_empty;
    assign qhv_stall_o    = qhv_am_load_i & w_full & ~w_pop & ~qhv_clr_i;
    assign qhv_count_o    = r_count;
    assign qhv_full_o     = w_full;
    assign qhv_empty_o    = w_empty;

endmodule

// File: tb/tb_qhv_fifo.sv
// Self-checking bench for qhv_fifo: directed scenarios plus randomized traffic
// compared against a queue-based model of the committed queries.
module tb_qhv_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [W-1:0]  qhv_i;
    logic          qhv_wen_i;
    logic          qhv_clr_i;
    logic          qhv_am_load_i;
    logic [W-1:0]  qhv_o;
    logic [W-1:0]  am_qhv_o;
    logic          am_qhv_valid_o;
    logic          am_qhv_ready_i;
    logic          qhv_stall_o;
    logic [CW-1:0] qhv_count_o;
    logic          qhv_full_o;
    logic          qhv_empty_o;

    qhv_fifo #(.HVDimension(W), .QHVFifoDepth(DEPTH)) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .qhv_i          (qhv_i),
        .qhv_wen_i      (qhv_wen_i),
        .qhv_clr_i      (qhv_clr_i),
        .qhv_am_load_i  (qhv_am_load_i),
        .qhv_o          (qhv_o),
        .am_qhv_o       (am_qhv_o),
        .am_qhv_valid_o (am_qhv_valid_o),
        .am_qhv_ready_i (am_qhv_ready_i),
        .qhv_stall_o    (qhv_stall_o),
        .qhv_count_o    (qhv_count_o),
        .qhv_full_o     (qhv_full_o),
        .qhv_empty_o    (qhv_empty_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed queries in arrival order plus the staging value.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_stage;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        check_val("qhv_o", 32'(qhv_o), 32'(m_stage));
        check_val("count", 32'(qhv_count_o), 32'(m_q.size()));
        check_val("full", 32'(qhv_full_o), 32'(m_q.size() == DEPTH));
        check_val("empty", 32'(qhv_empty_o), 32'(m_q.size() == 0));
        check_val("valid", 32'(am_qhv_valid_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check_val("head", 32'(am_qhv_o), 32'(m_q[0]));
    endtask

    // One clock: drive at the falling edge, check combinational outputs before the
    // rising edge, update the model on it, check registered state at the next fall.
    task automatic cycle(input logic wen, input logic [W-1:0] d, input logic clr,
                         input logic load, input logic ready);
        logic pop, push, full, exp_stall;
        qhv_wen_i      = wen;
        qhv_i          = d;
        qhv_clr_i      = clr;
        qhv_am_load_i  = load;
        am_qhv_ready_i = ready;
        #1;
        full      = (m_q.size() == DEPTH);
        pop       = (m_q.size() != 0) && ready;
        push      = load && (!full || pop);
        exp_stall = load && full && !pop && !clr;
        check_val("stall", 32'(qhv_stall_o), 32'(exp_stall));
        if (m_q.size() != 0) check_val("am_head", 32'(am_qhv_o), 32'(m_q[0]));
        @(posedge clk_i);
        if (clr) begin
            m_q.delete();
            m_stage = '0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(m_stage);
            if (wen) m_stage = d;
        end
        @(negedge clk_i);
        $display("cyc wen=%0b d=%02h clr=%0b load=%0b rdy=%0b -> cnt=%0d stage=%02h head=%02h v=%0b",
                 wen, d, clr, load, ready, qhv_count_o, qhv_o, am_qhv_o, am_qhv_valid_o);
        check_state();
    endtask

    initial begin
        rst_ni = 1'b0;
        qhv_i = '0; qhv_wen_i = 0; qhv_clr_i = 0; qhv_am_load_i = 0; am_qhv_ready_i = 0;
        m_stage = '0;
        repeat (3) @(negedge clk_i);
        check_val("rst_qhv_o", 32'(qhv_o), 32'h0);
        check_val("rst_am_qhv", 32'(am_qhv_o), 32'h0);
        rst_ni = 1'b1;
        cycle(0, 8'h00, 0, 0, 0);
        check_val("idle_stall", 32'(qhv_stall_o), 32'h0);

        // Write then commit, then a single drain.
        cycle(1, 8'hA5, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        check_val("a5_head", 32'(am_qhv_o), 32'hA5);
        cycle(0, 8'h00, 0, 0, 1);
        check_val("a5_drained", 32'(am_qhv_valid_o), 32'h0);

        // Same-cycle write and commit: the old staging value is committed.
        cycle(1, 8'h11, 0, 0, 0);
        cycle(1, 8'h3C, 0, 1, 0);
        check_val("wc_entry", 32'(am_qhv_o), 32'h11);
        check_val("wc_stage", 32'(qhv_o), 32'h3C);
        cycle(0, 8'h00, 0, 0, 1);

        // Fill, stall, then full push with same-cycle pop.
        cycle(1, 8'h01, 0, 0, 0);
        cycle(1, 8'h02, 0, 1, 0);
        cycle(1, 8'h03, 0, 1, 0);
        check_val("fill_full", 32'(qhv_full_o), 32'h1);
        cycle(0, 8'h00, 0, 1, 0);
        check_val("stall_head", 32'(am_qhv_o), 32'h01);
        cycle(0, 8'h00, 0, 1, 1);
        check_val("fullpop_head", 32'(am_qhv_o), 32'h02);
        check_val("fullpop_cnt", 32'(qhv_count_o), 32'h2);
        cycle(0, 8'h00, 0, 0, 1);
        check_val("drain_03", 32'(am_qhv_o), 32'h03);
        cycle(0, 8'h00, 0, 0, 1);

        // Clear while full with commit and ready asserted.
        cycle(1, 8'hAA, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        cycle(1, 8'h77, 0, 1, 0);
        cycle(0, 8'h00, 1, 1, 1);
        check_val("clr_cnt", 32'(qhv_count_o), 32'h0);
        check_val("clr_stage", 32'(qhv_o), 32'h0);

        // Back-to-back commits of 0..9 with the AM always ready.
        cycle(1, 8'h00, 0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            cycle(1, W'(i), 0, 1, 1);
            check_val("b2b_head", 32'(am_qhv_o), 32'(i - 1));
            check_val("b2b_cnt_le1", 32'(qhv_count_o <= 1), 32'h1);
        end
        cycle(0, 8'h00, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 2) == 0), W'($urandom), ($urandom_range(0, 30) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset in the middle of operation discards everything.
        cycle(1, 8'h5A, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        #2 rst_ni = 1'b0;
        #1;
        m_q.delete();
        m_stage = '0;
        check_val("arst_count", 32'(qhv_count_o), 32'h0);
        check_val("arst_valid", 32'(am_qhv_valid_o), 32'h0);
        check_val("arst_qhv_o", 32'(qhv_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qhv_fifo.md
Name: qhv_fifo

Overview:
- Next-generation query hypervector holding block between the encoder datapath and the associative memory (AM).
- Splits the query path in two:
  - a staging register that the encoder writes and reads back freely;
  - a parametrised-depth FIFO of committed queries that drains to the AM through a valid-ready handshake.
- Removes the encoder's dependency on AM busy state. The encoder stalls only when the FIFO cannot accept a commit.

Parameters:
- HVDimension, 512, hypervector width in bits.
- QHVFifoDepth, 4, number of committed-query entries; integer >= 1, need not be a power of two.
- PtrWidth, derived = max(1, $clog2(QHVFifoDepth)), read/write pointer width.
- CntWidth, derived = $clog2(QHVFifoDepth+1), occupancy counter width.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- qhv_i  input  HVDimension  encoder result to load into staging register
- qhv_wen_i  input  1  write staging register
- qhv_clr_i  input  1  synchronous clear of staging register and FIFO
- qhv_am_load_i  input  1  commit (push) current staging contents into FIFO
- qhv_o  output  HVDimension  staging register contents (encoder readback)
- am_qhv_o  output  HVDimension  FIFO head entry to AM
- am_qhv_valid_o  output  1  FIFO head valid (FIFO non-empty)
- am_qhv_ready_i  input  1  AM accepts head
- qhv_stall_o  output  1  commit request cannot be accepted this cycle
- qhv_count_o  output  CntWidth  FIFO occupancy
- qhv_full_o  output  1  occupancy == QHVFifoDepth
- qhv_empty_o  output  1  occupancy == 0

Behaviour:
Reset (async, rst_ni low):
- Staging register, all storage entries, pointers and count go to 0.
- Resulting outputs: qhv_o=0, am_qhv_o=0, am_qhv_valid_o=0, qhv_stall_o=0, qhv_count_o=0, qhv_full_o=0, qhv_empty_o=1.
- Reset mid-operation discards all entries.

Clear (qhv_clr_i=1):
- Highest priority: at the next edge, the staging register, pointers and count are zeroed.
- Same-cycle wen, commit and pop are ignored, so no count change from them.
- Storage contents need not be zeroed.
- qhv_stall_o is forced to 0 while qhv_clr_i=1.

Staging write:
- qhv_wen_i=1 loads qhv_i into the staging register at the edge.
- Always allowed; independent of FIFO state.

Pop:
- pop = am_qhv_valid_o & am_qhv_ready_i.
- On pop: read pointer advances, wrapping from QHVFifoDepth-1 to 0.

Push:
- push = qhv_am_load_i & (~qhv_full_o | pop).
- On push: storage[wr_ptr] receives the staging value present BEFORE this edge. A same-cycle qhv_wen_i affects the staging register only, never the pushed entry.
- Write pointer advances with the same wrap rule.

Occupancy:
- count increments on push only, decrements on pop only, unchanged on both or neither.
- count never exceeds QHVFifoDepth and never underflows.

Stall:
- qhv_stall_o = qhv_am_load_i & qhv_full_o & ~pop & ~qhv_clr_i.
- A stalled commit is dropped. The requester must hold qhv_am_load_i until qhv_stall_o=0.
- The staging register keeps its value, so a retry pushes the same data.

Output timing:
- am_qhv_o is combinational from storage[rd_ptr]. Data is only meaningful while am_qhv_valid_o=1.
- am_qhv_valid_o = ~qhv_empty_o.
- Push-to-valid latency: 1 cycle, with no combinational bypass from staging to am_qhv_o.
- Registered-full push with same-cycle pop: accepted. Count stays at QHVFifoDepth; the head advances and the new entry goes to the tail.
- The AM may hold am_qhv_ready_i high continuously: one entry drains per cycle.

Test Plan:
(Bench uses HVDimension=8, QHVFifoDepth=2.)
- Reset, then idle -> qhv_o=0x00, am_qhv_valid_o=0, qhv_empty_o=1, qhv_count_o=0, qhv_stall_o=0.
- Write 0xA5, then commit with ready=0 -> next cycle am_qhv_valid_o=1, am_qhv_o=0xA5, count=1. Then ready=1 for one cycle -> valid=0, count=0.
- Same-cycle qhv_wen_i with qhv_i=0x3C and commit while staging=0x11 -> FIFO entry=0x11, qhv_o=0x3C next cycle.
- Commit 0x01 and 0x02 with ready=0 -> full=1, count=2. Third commit of 0x03 -> qhv_stall_o=1, count stays 2, head stays 0x01. Assert ready in the same cycle -> stall=0, 0x03 pushed, head becomes 0x02, count=2. Drain order 0x02 then 0x03.
- FIFO full plus staging 0x77, then assert qhv_clr_i together with commit and ready -> next cycle count=0, valid=0, qhv_o=0x00, stall=0 during clear.
- Ten back-to-back commits of values 0..9 with ready=1 every cycle -> AM receives 0..9 in order, each 1 cycle after its commit. Count never exceeds 1, no stall, and pointer wrap is exercised.
